// File: rtl/phy_tx_idle_arbiter_pkg.sv
// phy_pd_defs: shared encodings and default timing constants for the PD PHY tx idle arbiter.
// Contents: FSM state encoding, transmitter owner encoding, retry/backoff/IFG defaults,
// and the idle-detector period used for latency reasoning.
package phy_pd_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_BACKOFF = 3'd2,
        ST_GRANT   = 3'd3,
        ST_IFG     = 3'd4
    } state_e;

    typedef enum logic {
        OWN_MSG  = 1'b0,
        OWN_HRST = 1'b1
    } owner_e;

    localparam int RETRY_MAX_DEF      = 3;
    localparam int BACKOFF_CYCLES_DEF = 16;
    localparam int IFG_CYCLES_DEF     = 8;
    localparam int CNT_W_DEF          = 5;
    // Counts of the external idle detector before it raises done.
    localparam int IDLE_DET_PERIOD    = 30;

endpackage

// File: rtl/phy_tx_idle_arbiter_timer.sv
// phy_tx_idle_timer: loadable down-counter with zero flag, shared by backoff and interframe gap.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   load_i     load load_val_i this cycle (overrides counting)
//   load_val_i value to load
//   zero_o     counter is zero
module phy_tx_idle_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phy_tx_idle_arbiter.sv
// phy_tx_idle_arbiter: collision-avoidance sequencer arbitrating hard reset vs message tx.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_msg, req_hrst       level requests (hard reset has priority)
//   idle_en                 enable for the external idle detector
//   idle_done, idle_result  detector completion and result (1 = line idle)
//   tx_done                 end-of-frame pulse from the transmitter
//   grant_msg, grant_hrst   level grants, mutually exclusive
//   tx_start                one-cycle pulse on grant entry
//   fail_msg                one-cycle pulse when message retries run out
//   arb_busy                high whenever the FSM is not idle
module phy_tx_idle_arbiter
    import phy_pd_defs::*;
#(
    parameter int RETRY_MAX      = RETRY_MAX_DEF,
    parameter int BACKOFF_CYCLES = BACKOFF_CYCLES_DEF,
    parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_msg,
    input  logic req_hrst,
    output logic idle_en,
    input  logic idle_done,
    input  logic idle_result,
    input  logic tx_done,
    output logic grant_msg,
    output logic grant_hrst,
    output logic tx_start,
    output logic fail_msg,
    output logic arb_busy
);

    localparam int RW = $clog2(RETRY_MAX + 1);

    state_e           state_q;
    owner_e           owner_q;
    logic [RW-1:0]    retry_q;
    logic             idle_en_q, grant_msg_q, grant_hrst_q, tx_start_q, fail_msg_q, arb_busy_q;
    logic             own_req, chk_busy, msg_fail, tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    // The current owner's request line; its withdrawal aborts CHECK/BACKOFF.
    assign own_req  = (owner_q == OWN_HRST) ? req_hrst : req_msg;
    assign chk_busy = (state_q == ST_CHECK) && own_req && idle_done && !idle_result;
    assign msg_fail = chk_busy && (owner_q == OWN_MSG) && (retry_q == RW'(RETRY_MAX - 1));
    assign tmr_load = (chk_busy && !msg_fail) || ((state_q == ST_GRANT) && tx_done);
    // Loaded with N-1 so the zero cycle is the last of N cycles in the state.
    assign tmr_val  = (state_q == ST_GRANT) ? CNT_W'(IFG_CYCLES - 1) : CNT_W'(BACKOFF_CYCLES - 1);

    phy_tx_idle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_MSG;
            retry_q      <= '0;
            idle_en_q    <= 1'b0;
            grant_msg_q  <= 1'b0;
            grant_hrst_q <= 1'b0;
            tx_start_q   <= 1'b0;
            fail_msg_q   <= 1'b0;
            arb_busy_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            fail_msg_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_hrst || req_msg) begin
                        owner_q    <= req_hrst ? OWN_HRST : OWN_MSG;
                        state_q    <= ST_CHECK;
                        idle_en_q  <= 1'b1;
                        arb_busy_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!own_req) begin
                        state_q    <= ST_IDLE;
                        idle_en_q  <= 1'b0;
                        arb_busy_q <= 1'b0;
                        retry_q    <= '0;
                    end else if (idle_done) begin
                        idle_en_q <= 1'b0;
                        if (idle_result) begin
                            state_q      <= ST_GRANT;
                            grant_msg_q  <= (owner_q == OWN_MSG);
                            grant_hrst_q <= (owner_q == OWN_HRST);
                            tx_start_q   <= 1'b1;
                            retry_q      <= '0;
                        end else if (msg_fail) begin
                            state_q    <= ST_IDLE;
                            fail_msg_q <= 1'b1;
                            arb_busy_q <= 1'b0;
                            retry_q    <= '0;
                        end else begin
                            state_q <= ST_BACKOFF;
                            retry_q <= (retry_q == {RW{1'b1}}) ? retry_q : retry_q + 1'b1;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (!own_req) begin
                        state_q    <= ST_IDLE;
                        arb_busy_q <= 1'b0;
                        retry_q    <= '0;
                    end else if (tmr_zero) begin
                        state_q   <= ST_CHECK;
                        idle_en_q <= 1'b1;
                        // A pending hard reset takes over the next check with a fresh retry count.
                        if (owner_q == OWN_MSG && req_hrst) begin
                            owner_q <= OWN_HRST;
                            retry_q <= '0;
                        end
                    end
                end
                ST_GRANT: begin
                    if (tx_done) begin
                        state_q      <= ST_IFG;
                        grant_msg_q  <= 1'b0;
                        grant_hrst_q <= 1'b0;
                    end
                end
                ST_IFG: begin
                    if (tmr_zero) begin
                        state_q    <= ST_IDLE;
                        arb_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    idle_en_q  <= 1'b0;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign idle_en    = idle_en_q;
    assign grant_msg  = grant_msg_q;
    assign grant_hrst = grant_hrst_q;
    assign tx_start   = tx_start_q;
    assign fail_msg   = fail_msg_q;
    assign arb_busy   = arb_busy_q;

endmodule

// File: tb/tb_phy_tx_idle_arbiter.sv
// tb_phy_tx_idle_arbiter: directed bench for phy_tx_idle_arbiter with a behavioural idle detector.
module tb_phy_tx_idle_arbiter;
    import phy_pd_defs::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_msg = 1'b0, req_hrst = 1'b0, tx_done = 1'b0, line_quiet = 1'b1;
    logic idle_en, idle_done, idle_result, grant_msg, grant_hrst, tx_start, fail_msg, arb_busy;
    logic [5:0] outs;
    int det_cnt;
    int total = 0, bad = 0;

    phy_tx_idle_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_msg     (req_msg),
        .req_hrst    (req_hrst),
        .idle_en     (idle_en),
        .idle_done   (idle_done),
        .idle_result (idle_result),
        .tx_done     (tx_done),
        .grant_msg   (grant_msg),
        .grant_hrst  (grant_hrst),
        .tx_start    (tx_start),
        .fail_msg    (fail_msg),
        .arb_busy    (arb_busy)
    );

    always #5 clk = ~clk;

    // Detector: counts IDLE_DET_PERIOD cycles while enabled, then one done cycle, then restarts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_cnt <= 0;
        else if (!idle_en || det_cnt == IDLE_DET_PERIOD) det_cnt <= 0;
        else det_cnt <= det_cnt + 1;
    end
    assign idle_done   = idle_en && (det_cnt == IDLE_DET_PERIOD);
    assign idle_result = line_quiet;

    // {idle_en, grant_msg, grant_hrst, tx_start, fail_msg, arb_busy}
    assign outs = {idle_en, grant_msg, grant_hrst, tx_start, fail_msg, arb_busy};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic finish_tx();
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(8);
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL ifg_to_idle: outs=%b want 000000", outs); end
    endtask

    task automatic test_reset();
        tick(2);
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL reset_hold: outs=%b want 000000", outs); end
        rst_n = 1'b1;
        tick(3);
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL reset_release: outs=%b want 000000", outs); end
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(1);
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL stray_tx_done: outs=%b want 000000", outs); end
    endtask

    task automatic test_quiet_msg();
        req_msg = 1'b1;
        tick(1);
        total++;
        if (outs !== 6'b100001) begin bad++; $display("FAIL quiet_check_entry: outs=%b want 100001", outs); end
        tick(30);
        total++;
        if (outs !== 6'b100001) begin bad++; $display("FAIL quiet_before_grant: outs=%b want 100001", outs); end
        tick(1);
        total++;
        if (outs !== 6'b010101) begin bad++; $display("FAIL quiet_grant: outs=%b want 010101", outs); end
        req_msg = 1'b0;
        tick(1);
        total++;
        if (outs !== 6'b010001) begin bad++; $display("FAIL quiet_start_pulse: outs=%b want 010001", outs); end
        tick(25);
        total++;
        if (outs !== 6'b010001) begin bad++; $display("FAIL quiet_grant_hold: outs=%b want 010001", outs); end
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        total++;
        if (outs !== 6'b000001) begin bad++; $display("FAIL quiet_grant_drop: outs=%b want 000001", outs); end
        tick(7);
        total++;
        if (outs !== 6'b000001) begin bad++; $display("FAIL quiet_ifg_last: outs=%b want 000001", outs); end
        tick(1);
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL quiet_ifg_idle: outs=%b want 000000", outs); end
    endtask

    task automatic test_busy_fail();
        int first_fail = -1, fails = 0, grants = 0, checks = 0;
        logic prev_en = 1'b0;
        logic [5:0] snap40 = '0, snap126 = '0;
        line_quiet = 1'b0;
        req_msg = 1'b1;
        for (int e = 1; e <= 130; e++) begin
            tick(1);
            if (fail_msg) begin
                if (first_fail < 0) first_fail = e;
                fails++;
                req_msg = 1'b0;
            end
            if (grant_msg || grant_hrst || tx_start) grants++;
            if (idle_en && !prev_en) checks++;
            prev_en = idle_en;
            if (e == 40) snap40 = outs;
            if (e == 126) snap126 = outs;
        end
        line_quiet = 1'b1;
        total++;
        if (first_fail != 126) begin bad++; $display("FAIL busy_fail_cycle: got %0d want 126", first_fail); end
        total++;
        if (fails != 1) begin bad++; $display("FAIL busy_fail_count: got %0d want 1", fails); end
        total++;
        if (grants != 0) begin bad++; $display("FAIL busy_no_grant: got %0d want 0", grants); end
        total++;
        if (checks != 3) begin bad++; $display("FAIL busy_check_count: got %0d want 3", checks); end
        total++;
        if (snap40 !== 6'b000001) begin bad++; $display("FAIL busy_backoff_outs: outs=%b want 000001", snap40); end
        total++;
        if (snap126 !== 6'b000010) begin bad++; $display("FAIL busy_fail_outs: outs=%b want 000010", snap126); end
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL busy_end_idle: outs=%b want 000000", outs); end
    endtask

    task automatic test_simultaneous();
        req_msg = 1'b1;
        req_hrst = 1'b1;
        tick(32);
        total++;
        if (outs !== 6'b001101) begin bad++; $display("FAIL simul_hrst_grant: outs=%b want 001101", outs); end
        req_hrst = 1'b0;
        tick(8);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        total++;
        if (outs !== 6'b000001) begin bad++; $display("FAIL simul_hrst_drop: outs=%b want 000001", outs); end
        tick(39);
        total++;
        if (outs !== 6'b100001) begin bad++; $display("FAIL simul_msg_check: outs=%b want 100001", outs); end
        tick(1);
        total++;
        if (outs !== 6'b010101) begin bad++; $display("FAIL simul_msg_grant: outs=%b want 010101", outs); end
        req_msg = 1'b0;
        finish_tx();
    endtask

    task automatic test_upgrade();
        int ev = 0;
        line_quiet = 1'b0;
        req_msg = 1'b1;
        tick(36);
        total++;
        if (outs !== 6'b000001) begin bad++; $display("FAIL upg_backoff: outs=%b want 000001", outs); end
        req_hrst = 1'b1;
        line_quiet = 1'b1;
        tick(42);
        total++;
        if (outs !== 6'b100001) begin bad++; $display("FAIL upg_check: outs=%b want 100001", outs); end
        tick(1);
        total++;
        if (outs !== 6'b001101) begin bad++; $display("FAIL upg_hrst_grant: outs=%b want 001101", outs); end
        req_hrst = 1'b0;
        req_msg = 1'b0;
        finish_tx();
        line_quiet = 1'b0;
        req_hrst = 1'b1;
        for (int e = 1; e <= 501; e++) begin
            tick(1);
            if (e == 460) line_quiet = 1'b1;
            if (fail_msg || grant_msg || grant_hrst || tx_start || !arb_busy) ev++;
        end
        total++;
        if (ev != 0) begin bad++; $display("FAIL hrst_never_fails: events=%0d want 0", ev); end
        tick(1);
        total++;
        if (outs !== 6'b001101) begin bad++; $display("FAIL hrst_late_grant: outs=%b want 001101", outs); end
        req_hrst = 1'b0;
        finish_tx();
    endtask

    task automatic test_withdraw();
        int ev = 0;
        req_msg = 1'b1;
        tick(10);
        total++;
        if (outs !== 6'b100001) begin bad++; $display("FAIL wd_check: outs=%b want 100001", outs); end
        req_msg = 1'b0;
        tick(1);
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL wd_abort: outs=%b want 000000", outs); end
        for (int e = 0; e < 40; e++) begin
            tick(1);
            if (outs !== 6'b000000) ev++;
        end
        total++;
        if (ev != 0) begin bad++; $display("FAIL wd_quiet: events=%0d want 0", ev); end
    endtask

    task automatic test_reset_mid_grant();
        req_msg = 1'b1;
        tick(32);
        total++;
        if (outs !== 6'b010101) begin bad++; $display("FAIL rst_pre_grant: outs=%b want 010101", outs); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs !== 6'b000000) begin bad++; $display("FAIL rst_async_clear: outs=%b want 000000", outs); end
        tick(1);
        rst_n = 1'b1;
        tick(31);
        total++;
        if (outs !== 6'b100001) begin bad++; $display("FAIL rst_restart_check: outs=%b want 100001", outs); end
        tick(1);
        total++;
        if (outs !== 6'b010101) begin bad++; $display("FAIL rst_restart_grant: outs=%b want 010101", outs); end
        req_msg = 1'b0;
        finish_tx();
    endtask

    initial begin
        test_reset();
        test_quiet_msg();
        test_busy_fail();
        test_simultaneous();
        test_upgrade();
        test_withdraw();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
